// File: rtl/inv_subbytes_seq_if.sv
// Handshake and S-box bank bus for the inverse SubBytes sequencer.
// The slave modport is the sequencer side; master is the surrounding datapath.
interface inv_subbytes_seq_if #(
  parameter int N     = 128,
  parameter int LANES = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     in_state;
  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     out_state;
  logic [LANES-1:0] sb_in;
  logic [LANES-1:0] sb_out;
  logic             busy;

  modport slave (
    input  in_valid, in_state, out_ready, sb_out,
    output in_ready, out_valid, out_state, sb_in, busy
  );

  modport master (
    output in_valid, in_state, out_ready, sb_out,
    input  in_ready, out_valid, out_state, sb_in, busy
  );
endinterface

// File: rtl/inv_subbytes_seq.sv
// Walks one AES state through a narrow external inverse S-box bank, LANES bits per cycle,
// and presents the reassembled result with a valid/ready handshake.
//
//   state | meaning
//   IDLE  | waiting for a state; in_ready high
//   RUN   | one beat per cycle through the S-box bank, lowest chunk first
//   DONE  | result held on out_state until out_ready
module inv_subbytes_seq #(
  parameter int N     = 128,
  parameter int LANES = 32
) (
  input  logic               clk,
  input  logic               reset,
  inv_subbytes_seq_if.slave  bus
);
  localparam int BEATS = N / LANES;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] beat;
  logic [N-1:0]  stored;
  logic [N-1:0]  result;
  logic          last_beat;

  assign last_beat = (beat == CW'(BEATS - 1));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid)  state_nxt = RUN;
      RUN:     if (last_beat)     state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  // sb_in is forced to zero outside RUN so the bank never sees stale data
  always_comb begin
    bus.in_ready  = (state == IDLE);
    bus.out_valid = (state == DONE);
    bus.busy      = (state != IDLE);
    bus.out_state = result;
    bus.sb_in     = '0;
    if (state == RUN) bus.sb_in = stored[int'(beat)*LANES +: LANES];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      beat   <= '0;
      stored <= '0;
      result <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            stored <= bus.in_state;
            beat   <= '0;
          end
        end
        RUN: begin
          result[int'(beat)*LANES +: LANES] <= bus.sb_out;
          if (!last_beat) beat <= beat + CW'(1);
        end
        default: ;
      endcase
    end
  end
endmodule
